sram_phy_seq: RTL and testbench

Back-end sequencer for the sram_ctrl IP. It sits directly downstream of the AXI4-Lite slave register/decode logic and turns one word-wide command from a valid/ready command channel into a correctly timed asynchronous SRAM read or write cycle. Read data and write completion return on a valid/ready response channel. Exactly one transaction is outstanding at any time, and the wait states are set by parameters.

---
 rtl/sram_phy_seq.sv | 187 ++++++++++++++++++
 tb/tb_sram_phy_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_phy_seq.sv
// Back-end sequencer: one valid/ready command -> one timed asynchronous SRAM read or write cycle.
// Optional macro SRAM_PHY_TURNAROUND_EN adds a TURN cycle after each read response.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | cmd_ready high, waiting for a command
// SETUP    | ce_n low, address (and write data/byte enables) presented
// RD_ACC   | oe_n low for RD_WAIT cycles, data captured on the last edge
// WR_PULSE | we_n low for WR_WAIT cycles
// WR_HOLD  | we_n high, address/data/dq_oe still held
// RESP     | rsp_valid high until rsp_ready is sampled
// TURN     | bus turnaround after a read (SRAM_PHY_TURNAROUND_EN only)
module sram_phy_seq #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32,
  parameter int RD_WAIT    = 2,
  parameter int WR_WAIT    = 2
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_dq_o,
  output logic                    sram_dq_oe,
  input  logic [DATA_WIDTH-1:0]   sram_dq_i,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic [DATA_WIDTH/8-1:0] sram_be_n
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam logic [3:0] RD_CNT = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, RD_ACC, WR_PULSE, WR_HOLD, RESP, TURN
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [BE_W-1:0]         be_sel_q, be_sel_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0]   sram_dq_o_q, sram_dq_o_d;
  logic                    sram_dq_oe_q, sram_dq_oe_d;
  logic                    sram_ce_n_q, sram_ce_n_d;
  logic                    sram_oe_n_q, sram_oe_n_d;
  logic                    sram_we_n_q, sram_we_n_d;
  logic [BE_W-1:0]         sram_be_n_q, sram_be_n_d;
  logic                    bus_active;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    be_sel_d    = be_sel_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    sram_addr_d = sram_addr_q;
    sram_dq_o_d = sram_dq_o_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = SETUP;
          wr_d        = cmd_write;
          sram_addr_d = cmd_addr;
          if (cmd_write) begin
            sram_dq_o_d = cmd_wdata;
            be_sel_d    = ~cmd_wstrb;
          end else begin
            be_sel_d    = '0;
          end
        end
      end
      SETUP: begin
        state_d = wr_q ? WR_PULSE : RD_ACC;
        cnt_d   = wr_q ? WR_CNT : RD_CNT;
      end
      RD_ACC: begin
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          rsp_rdata_d = sram_dq_i;
          rsp_write_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_HOLD: begin
        state_d     = RESP;
        rsp_write_d = 1'b1;
      end
      RESP: begin
        if (rsp_ready) begin
`ifdef SRAM_PHY_TURNAROUND_EN
          state_d = wr_q ? IDLE : TURN;
`else
          state_d = IDLE;
`endif
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    bus_active   = (state_d == SETUP) || (state_d == RD_ACC) ||
                   (state_d == WR_PULSE) || (state_d == WR_HOLD);
    cmd_ready_d  = (state_d == IDLE);
    rsp_valid_d  = (state_d == RESP);
    sram_ce_n_d  = ~bus_active;
    sram_oe_n_d  = (state_d != RD_ACC);
    sram_we_n_d  = (state_d != WR_PULSE);
    sram_dq_oe_d = bus_active && wr_d;
    sram_be_n_d  = bus_active ? be_sel_d : '1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      be_sel_q     <= '1;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_write_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      sram_addr_q  <= '0;
      sram_dq_o_q  <= '0;
      sram_dq_oe_q <= 1'b0;
      sram_ce_n_q  <= 1'b1;
      sram_oe_n_q  <= 1'b1;
      sram_we_n_q  <= 1'b1;
      sram_be_n_q  <= '1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      be_sel_q     <= be_sel_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_write_q  <= rsp_write_d;
      rsp_rdata_q  <= rsp_rdata_d;
      sram_addr_q  <= sram_addr_d;
      sram_dq_o_q  <= sram_dq_o_d;
      sram_dq_oe_q <= sram_dq_oe_d;
      sram_ce_n_q  <= sram_ce_n_d;
      sram_oe_n_q  <= sram_oe_n_d;
      sram_we_n_q  <= sram_we_n_d;
      sram_be_n_q  <= sram_be_n_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign sram_addr  = sram_addr_q;
  assign sram_dq_o  = sram_dq_o_q;
  assign sram_dq_oe = sram_dq_oe_q;
  assign sram_ce_n  = sram_ce_n_q;
  assign sram_oe_n  = sram_oe_n_q;
  assign sram_we_n  = sram_we_n_q;
  assign sram_be_n  = sram_be_n_q;

endmodule

// File: tb/tb_sram_phy_seq.sv
// Directed bench for sram_phy_seq with a small behavioural SRAM on the pins.
// Latencies count the accept cycle as cycle 0; outputs sampled 1 time unit after each rising edge.
module tb_sram_phy_seq;

  logic        ACLK;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [17:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [17:0] sram_addr;
  logic [31:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;

  sram_phy_seq dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [31:0] mem [0:15];

  always @(posedge ACLK) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      for (int b = 0; b < 4; b++) begin
        if (!sram_be_n[b]) mem[sram_addr[3:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
      end
    end
  end

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[3:0]] : 32'h0;

  int total = 0;
  int bad   = 0;
  int n_we, n_dqoe, n_rd, n_ce, lat;
  logic [3:0]  be_seen;
  logic [31:0] held;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
    if (!sram_we_n) begin
      n_we++;
      be_seen = sram_be_n;
    end
    if (sram_dq_oe) n_dqoe++;
    if (!sram_oe_n) n_rd++;
    if (!sram_ce_n) n_ce++;
  endtask

  // Issues one command and returns once rsp_valid is seen (or a 40-cycle budget runs out).
  task automatic do_cmd(input logic wr, input logic [17:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    int guard = 0;
    while (!cmd_ready && guard < 20) begin
      step();
      guard++;
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n_we = 0; n_dqoe = 0; n_rd = 0; n_ce = 0; be_seen = 4'hx;
    step();
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic finish_rsp(input logic was_read, input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
`ifdef SRAM_PHY_TURNAROUND_EN
    if (was_read) begin
      chk({tag, "_turn_ready"}, cmd_ready, 1'b0);
      step();
    end
`endif
    chk({tag, "_ready_back"}, cmd_ready, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_write, rsp_rdata}, 34'h0);
    chk({tag, "_strobes"}, {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_be_n}, 8'hEF);
    chk({tag, "_addr_dq"}, {sram_addr, sram_dq_o}, 50'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    n_we = 0; n_dqoe = 0; n_rd = 0; n_ce = 0; be_seen = '0; lat = 0;

    step(); step();
    chk_reset_vals("por");
    ARESET = 1'b0;
    step();
    chk("por_ready", cmd_ready, 1'b1);

    // Full-word write
    do_cmd(1'b1, 18'h00004, 32'hDEAD0011, 4'hF);
    chk("wr_lat", lat, 5);
    chk("wr_rsp_write", rsp_write, 1'b1);
    chk("wr_we_cycles", n_we, 2);
    chk("wr_dqoe_cycles", n_dqoe, 4);
    chk("wr_ce_cycles", n_ce, 4);
    chk("wr_mem", mem[4], 32'hDEAD0011);
    finish_rsp(1'b0, "wr1");

    // Read it back
    do_cmd(1'b0, 18'h00004, 32'h0, 4'h0);
    chk("rd_lat", lat, 4);
    chk("rd_oe_cycles", n_rd, 2);
    chk("rd_no_dqoe", n_dqoe, 0);
    chk("rd_data", {rsp_write, rsp_rdata}, {1'b0, 32'hDEAD0011});
    finish_rsp(1'b1, "rd1");

    // Reset for 5 cycles while idle
    ARESET = 1'b1;
    repeat (5) step();
    chk_reset_vals("mid");
    ARESET = 1'b0;
    step();
    chk("mid_ready", cmd_ready, 1'b1);

    // Partial write over a preloaded word
    mem[8] = 32'hABCD0001;
    do_cmd(1'b1, 18'h00008, 32'hBEEF0011, 4'h3);
    chk("pw_be_n", be_seen, 4'hC);
    chk("pw_mem", mem[8], 32'hABCD0011);
    finish_rsp(1'b0, "pw");
    do_cmd(1'b0, 18'h00008, 32'h0, 4'h0);
    chk("pw_readback", rsp_rdata, 32'hABCD0011);
    finish_rsp(1'b1, "pr");

    // Write with no byte enables still completes
    mem[9] = 32'h12345678;
    do_cmd(1'b1, 18'h00009, 32'hFFFFFFFF, 4'h0);
    chk("z_lat", lat, 5);
    chk("z_rsp", {rsp_valid, rsp_write}, 2'b11);
    chk("z_be_n", be_seen, 4'hF);
    chk("z_mem", mem[9], 32'h12345678);
    finish_rsp(1'b0, "z");

    // Response back-pressure
    do_cmd(1'b0, 18'h00004, 32'h0, 4'h0);
    chk("bp_data", rsp_rdata, 32'hDEAD0011);
    held = rsp_rdata;
    n_ce = 0; n_dqoe = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold", {rsp_valid, cmd_ready, sram_ce_n, sram_oe_n, sram_we_n, rsp_write, rsp_rdata},
          {6'b101110, held});
    end
    chk("bp_no_bus", n_ce + n_dqoe, 0);
    finish_rsp(1'b1, "bp");

    // Reset in the second write-pulse cycle
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 18'h0000A;
    cmd_wdata = 32'h00000055; cmd_wstrb = 4'hF;
    step();
    cmd_valid = 1'b0;
    step(); step();
    chk("rst_pulse2_we", sram_we_n, 1'b0);
    ARESET = 1'b1;
    step();
    chk("rst_strobes", {sram_we_n, sram_dq_oe, sram_ce_n}, 3'b101);
    ARESET = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    chk("rst_no_rsp", seen, 0);
    chk("rst_ready", cmd_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
